timer_apb_regs: RTL and testbench

- APB3 slave register bank that sits directly upstream of the PWM/timer counter and drives its control, prescaler, max_count and compare inputs.
- Double-buffers the period/compare/prescaler values so changes never tear a running period.
- Captures the counter's timer_int pulse into a sticky, software-clearable interrupt with a maskable irq line for the SoC interrupt controller.

---
 rtl/timer_pkg.sv | 25 ++
 rtl/timer_apb_regs_if.sv | 25 ++
 rtl/timer_irq_capture.sv | 34 +++
 rtl/timer_apb_regs.sv | 141 ++++++++++++++
 tb/tb_timer_apb_regs.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// Shared constants for the timer APB register bank:
// register offsets, mode encodings, STATUS bit indices and ID value.
package timer_pkg;

  localparam int CTRL_OFS   = 'h00;
  localparam int PRESC_OFS  = 'h04;
  localparam int MAXC_OFS   = 'h08;
  localparam int CMP_OFS    = 'h0C;
  localparam int STATUS_OFS = 'h10;
  localparam int ID_OFS     = 'h14;

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'b00,
    MODE_TIMER = 2'b01,
    MODE_PWM   = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_e;

  localparam int CTRL_IRQ_EN_BIT = 2;
  localparam int STAT_INT_BIT    = 0;
  localparam int STAT_UPD_BIT    = 1;

  localparam logic [31:0] ID_VALUE = 32'h544D_0001;

endpackage

// File: rtl/timer_apb_regs_if.sv
// APB3 bus bundle between a master and the timer register bank.
// Ports: psel/penable/pwrite/paddr/pwdata in, prdata/pready/pslverr out.
interface timer_apb_regs_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/timer_irq_capture.sv
// Rising-edge capture of timer_int into a sticky W1C pending bit.
// Ports: clk, reset (sync, low), timer_int, clr, irq_en -> int_pending, irq.
module timer_irq_capture (
  input  logic clk,
  input  logic reset,
  input  logic timer_int,
  input  logic clr,
  input  logic irq_en,
  output logic int_pending,
  output logic irq
);

  logic int_q;
  logic rise;

  assign rise = timer_int & ~int_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      int_q       <= 1'b0;
      int_pending <= 1'b0;
    end else begin
      int_q <= timer_int;
      // a fresh edge beats a simultaneous clear
      if (rise)
        int_pending <= 1'b1;
      else if (clr)
        int_pending <= 1'b0;
    end
  end

  assign irq = int_pending & irq_en;

endmodule

// File: rtl/timer_apb_regs.sv
// APB3 register bank driving the PWM/timer counter with double-buffered
// period/compare/prescaler and a maskable sticky interrupt.
// Ports: clk, reset (sync, low), apb (slave), control, prescalor,
// max_count, compare, period_end, timer_int, irq.
module timer_apb_regs
  import timer_pkg::*;
#(
  parameter int          ADDR_W   = 5,
  parameter int          DATA_W   = 32,
  parameter logic [31:0] ID_VALUE = timer_pkg::ID_VALUE
) (
  input  logic              clk,
  input  logic              reset,
  timer_apb_regs_if.slave   apb,
  output logic [1:0]        control,
  output logic [DATA_W-1:0] prescalor,
  output logic [DATA_W-1:0] max_count,
  output logic [DATA_W-1:0] compare,
  input  logic              period_end,
  input  logic              timer_int,
  output logic              irq
);

  logic [1:0]        mode;
  logic              irq_en;
  logic [DATA_W-1:0] sh_presc;
  logic [DATA_W-1:0] sh_maxc;
  logic [DATA_W-1:0] sh_cmp;
  logic              upd_pend;
  logic              idle_load;
  logic              int_pending;

  logic setup;
  logic access;
  logic addr_err;
  logic wr;
  logic sel_ctrl, sel_presc, sel_maxc;
  logic sel_cmp, sel_stat, sel_id;
  logic wr_ctrl, wr_presc, wr_maxc;
  logic wr_cmp, wr_stat;
  logic shadow_wr;
  logic int_clr;
  logic is_idle;
  logic [DATA_W-1:0] rdata;

  assign setup  = apb.psel & ~apb.penable;
  assign access = apb.psel & apb.penable;

  assign sel_ctrl  = apb.paddr == ADDR_W'(CTRL_OFS);
  assign sel_presc = apb.paddr == ADDR_W'(PRESC_OFS);
  assign sel_maxc  = apb.paddr == ADDR_W'(MAXC_OFS);
  assign sel_cmp   = apb.paddr == ADDR_W'(CMP_OFS);
  assign sel_stat  = apb.paddr == ADDR_W'(STATUS_OFS);
  assign sel_id    = apb.paddr == ADDR_W'(ID_OFS);

  assign addr_err = (|apb.paddr[1:0])
                  | (apb.paddr > ADDR_W'(ID_OFS));

  assign wr       = access & apb.pwrite & ~addr_err;
  assign wr_ctrl  = wr & sel_ctrl;
  assign wr_presc = wr & sel_presc;
  assign wr_maxc  = wr & sel_maxc;
  assign wr_cmp   = wr & sel_cmp;
  assign wr_stat  = wr & sel_stat;

  assign shadow_wr = wr_presc | wr_maxc | wr_cmp;
  assign int_clr   = wr_stat & apb.pwdata[STAT_INT_BIT];
  assign is_idle   = mode == MODE_IDLE;

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      sel_ctrl:  rdata = DATA_W'({irq_en, mode});
      sel_presc: rdata = sh_presc;
      sel_maxc:  rdata = sh_maxc;
      sel_cmp:   rdata = sh_cmp;
      sel_stat:  rdata = DATA_W'({upd_pend, int_pending});
      sel_id:    rdata = DATA_W'(ID_VALUE);
      default:   rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mode        <= MODE_IDLE;
      irq_en      <= 1'b0;
      sh_presc    <= '0;
      sh_maxc     <= '0;
      sh_cmp      <= '0;
      prescalor   <= '0;
      max_count   <= '0;
      compare     <= '0;
      upd_pend    <= 1'b0;
      idle_load   <= 1'b0;
      apb.prdata  <= '0;
      apb.pslverr <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        mode   <= apb.pwdata[1:0];
        irq_en <= apb.pwdata[CTRL_IRQ_EN_BIT];
      end
      if (wr_presc) sh_presc <= apb.pwdata;
      if (wr_maxc)  sh_maxc  <= apb.pwdata;
      if (wr_cmp)   sh_cmp   <= apb.pwdata;

      // idle: copy shadows one cycle after the write lands
      idle_load <= shadow_wr & is_idle;

      // shadows sampled before any same-cycle write
      if (idle_load | period_end) begin
        prescalor <= sh_presc;
        max_count <= sh_maxc;
        compare   <= sh_cmp;
      end

      if (shadow_wr & ~is_idle)
        upd_pend <= 1'b1;
      else if (period_end | idle_load)
        upd_pend <= 1'b0;

      if (setup) begin
        apb.prdata  <= (!apb.pwrite && !addr_err) ? rdata : '0;
        apb.pslverr <= addr_err;
      end
    end
  end

  assign apb.pready = 1'b1;
  assign control    = mode;

  timer_irq_capture u_irq (
    .clk         (clk),
    .reset       (reset),
    .timer_int   (timer_int),
    .clr         (int_clr),
    .irq_en      (irq_en),
    .int_pending (int_pending),
    .irq         (irq)
  );

endmodule

// File: tb/tb_timer_apb_regs.sv
// Directed self-checking bench for timer_apb_regs.
// Drives APB on negedges; samples outputs on negedges.
module tb_timer_apb_regs;

  logic        clk;
  logic        reset;
  logic        period_end;
  logic        timer_int;
  logic [1:0]  control;
  logic [31:0] prescalor;
  logic [31:0] max_count;
  logic [31:0] compare;
  logic        irq;

  int errors;
  int checks;

  timer_apb_regs_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  timer_apb_regs dut (
    .clk        (clk),
    .reset      (reset),
    .apb        (bus),
    .control    (control),
    .prescalor  (prescalor),
    .max_count  (max_count),
    .compare    (compare),
    .period_end (period_end),
    .timer_int  (timer_int),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One APB transfer. pe/ti are applied in the access cycle.
  task automatic apb_xfer(
    input  logic        wr,
    input  logic [4:0]  addr,
    input  logic [31:0] data,
    input  logic        pe,
    input  logic        ti,
    output logic [31:0] rd,
    output logic        err
  );
    @(negedge clk);
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = wr;
    bus.paddr   = addr;
    bus.pwdata  = data;
    @(negedge clk);
    bus.penable = 1'b1;
    period_end  = pe;
    timer_int   = ti;
    rd  = bus.prdata;
    err = bus.pslverr;
    @(negedge clk);
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    period_end  = 1'b0;
  endtask

  task automatic pulse_pe();
    @(negedge clk);
    period_end = 1'b1;
    @(negedge clk);
    period_end = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic        err;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({control, prescalor, max_count, compare, irq} !== '0) begin
      errors++;
      $display("FAIL reset_outs got %b %h %h %h %b exp 0",
               control, prescalor, max_count, compare, irq);
    end
    checks++;
    if ({bus.prdata, bus.pslverr} !== '0) begin
      errors++;
      $display("FAIL reset_bus got %h %b exp 0", bus.prdata, bus.pslverr);
    end
    reset = 1'b1;
    apb_xfer(1'b0, 5'h14, 32'h0, 1'b0, 1'b0, rd, err);
    checks++;
    if (rd !== 32'h544D_0001 || err !== 1'b0) begin
      errors++;
      $display("FAIL id_read got %h err %b exp 544d0001 err 0", rd, err);
    end
    // reset in the access cycle aborts a MAXC write
    @(negedge clk);
    bus.psel = 1'b1; bus.pwrite = 1'b1;
    bus.paddr = 5'h08; bus.pwdata = 32'd77;
    @(negedge clk);
    bus.penable = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    apb_xfer(1'b0, 5'h08, 32'h0, 1'b0, 1'b0, rd, err);
    checks++;
    if (rd !== 32'h0 || max_count !== 32'h0) begin
      errors++;
      $display("FAIL reset_abort got %h %h exp 0 0", rd, max_count);
    end
  endtask

  task automatic test_idle_writes();
    logic [31:0] rd;
    logic        err;
    apb_xfer(1'b1, 5'h00, 32'h0, 1'b0, 1'b0, rd, err);
    apb_xfer(1'b1, 5'h08, 32'd100, 1'b0, 1'b0, rd, err);
    @(negedge clk);
    checks++;
    if (max_count !== 32'd100) begin
      errors++;
      $display("FAIL idle_maxc got %0d exp 100", max_count);
    end
    apb_xfer(1'b0, 5'h10, 32'h0, 1'b0, 1'b0, rd, err);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL idle_status got %h exp 0", rd);
    end
    apb_xfer(1'b1, 5'h04, 32'd7, 1'b0, 1'b0, rd, err);
    apb_xfer(1'b0, 5'h04, 32'h0, 1'b0, 1'b0, rd, err);
    checks++;
    if (rd !== 32'd7 || prescalor !== 32'd7) begin
      errors++;
      $display("FAIL idle_presc got %0d %0d exp 7 7", rd, prescalor);
    end
  endtask

  task automatic test_shadow();
    logic [31:0] rd;
    logic        err;
    apb_xfer(1'b1, 5'h0C, 32'd30, 1'b0, 1'b0, rd, err);
    apb_xfer(1'b1, 5'h00, 32'h2, 1'b0, 1'b0, rd, err);
    apb_xfer(1'b1, 5'h0C, 32'd60, 1'b0, 1'b0, rd, err);
    @(negedge clk);
    checks++;
    if (compare !== 32'd30 || control !== 2'b10) begin
      errors++;
      $display("FAIL shadow_hold got %0d %b exp 30 10", compare, control);
    end
    apb_xfer(1'b0, 5'h10, 32'h0, 1'b0, 1'b0, rd, err);
    checks++;
    if (rd !== 32'h2) begin
      errors++;
      $display("FAIL shadow_upd_set got %h exp 2", rd);
    end
    pulse_pe();
    checks++;
    if (compare !== 32'd60 || max_count !== 32'd100) begin
      errors++;
      $display("FAIL shadow_apply got %0d %0d exp 60 100", compare, max_count);
    end
    apb_xfer(1'b0, 5'h10, 32'h0, 1'b0, 1'b0, rd, err);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL shadow_upd_clr got %h exp 0", rd);
    end
  endtask

  task automatic test_collision();
    logic [31:0] rd;
    logic        err;
    apb_xfer(1'b1, 5'h08, 32'd200, 1'b1, 1'b0, rd, err);
    @(negedge clk);
    checks++;
    if (max_count !== 32'd100) begin
      errors++;
      $display("FAIL coll_old got %0d exp 100", max_count);
    end
    apb_xfer(1'b0, 5'h10, 32'h0, 1'b0, 1'b0, rd, err);
    checks++;
    if (rd !== 32'h2) begin
      errors++;
      $display("FAIL coll_upd got %h exp 2", rd);
    end
    pulse_pe();
    checks++;
    if (max_count !== 32'd200) begin
      errors++;
      $display("FAIL coll_new got %0d exp 200", max_count);
    end
  endtask

  task automatic test_interrupt();
    logic [31:0] rd;
    logic        err;
    apb_xfer(1'b1, 5'h00, 32'h5, 1'b0, 1'b0, rd, err);
    checks++;
    if (control !== 2'b01 || irq !== 1'b0) begin
      errors++;
      $display("FAIL int_ctrl got %b %b exp 01 0", control, irq);
    end
    timer_int = 1'b1;
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL int_set got %b exp 1", irq);
    end
    apb_xfer(1'b0, 5'h10, 32'h0, 1'b0, 1'b1, rd, err);
    checks++;
    if (rd !== 32'h1) begin
      errors++;
      $display("FAIL int_status got %h exp 1", rd);
    end
    timer_int = 1'b0;
    repeat (2) @(negedge clk);
    apb_xfer(1'b1, 5'h10, 32'h1, 1'b0, 1'b1, rd, err);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL int_set_wins got %b exp 1", irq);
    end
    timer_int = 1'b0;
    repeat (2) @(negedge clk);
    apb_xfer(1'b1, 5'h10, 32'h1, 1'b0, 1'b0, rd, err);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL int_w1c got %b exp 0", irq);
    end
    // a level that stays high must not re-trigger
    timer_int = 1'b1;
    @(negedge clk);
    apb_xfer(1'b1, 5'h10, 32'h1, 1'b0, 1'b1, rd, err);
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL int_level got %b exp 0", irq);
    end
    timer_int = 1'b0;
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    logic        err;
    apb_xfer(1'b0, 5'h18, 32'h0, 1'b0, 1'b0, rd, err);
    checks++;
    if (err !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL err_rd got %b %h exp 1 0", err, rd);
    end
    apb_xfer(1'b1, 5'h06, 32'hFFFF_FFFF, 1'b0, 1'b0, rd, err);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_wr got %b exp 1", err);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (control !== 2'b01 || prescalor !== 32'd7 ||
        max_count !== 32'd200 || compare !== 32'd60) begin
      errors++;
      $display("FAIL err_nochg got %b %0d %0d %0d exp 01 7 200 60",
               control, prescalor, max_count, compare);
    end
    apb_xfer(1'b1, 5'h14, 32'h0, 1'b0, 1'b0, rd, err);
    apb_xfer(1'b0, 5'h14, 32'h0, 1'b0, 1'b0, rd, err);
    checks++;
    if (rd !== 32'h544D_0001 || err !== 1'b0) begin
      errors++;
      $display("FAIL id_ro got %h %b exp 544d0001 0", rd, err);
    end
    apb_xfer(1'b0, 5'h00, 32'h0, 1'b0, 1'b0, rd, err);
    checks++;
    if (rd !== 32'h5 || err !== 1'b0) begin
      errors++;
      $display("FAIL ctrl_rd got %h %b exp 5 0", rd, err);
    end
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    reset       = 1'b0;
    period_end  = 1'b0;
    timer_int   = 1'b0;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    bus.paddr   = '0;
    bus.pwdata  = '0;
    test_reset();
    test_idle_writes();
    test_shadow();
    test_collision();
    test_interrupt();
    test_errors();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
